// File: rtl/aq_hpcp_cntint_ctrl_if.sv
// Purpose : software-write, overflow-event and interrupt signals between
//           the HPCP register front-end and the counter interrupt controller.
// Ports   : master drives write data/enables, overflow pulses and the global
//           interrupt enable; slave returns the enable/status vectors and the
//           registered interrupt request plus counter index.
interface aq_hpcp_cntint_ctrl_if #(
   parameter int CNT_NUM = 32,
   parameter int IDX_W   = 5
);
   logic [CNT_NUM-1:0] hpcp_wdata;
   logic [CNT_NUM-1:0] cntinten_wen;
   logic [CNT_NUM-1:0] cntof_wen;
   logic [CNT_NUM-1:0] cnt_of_pulse;
   logic               hpcp_int_gen_en;
   logic [CNT_NUM-1:0] cntinten;
   logic [CNT_NUM-1:0] cntof;
   logic               hpcp_int_req;
   logic [IDX_W-1:0]   hpcp_int_idx;

   modport master (
      output hpcp_wdata, cntinten_wen, cntof_wen, cnt_of_pulse, hpcp_int_gen_en,
      input  cntinten, cntof, hpcp_int_req, hpcp_int_idx
   );

   modport slave (
      input  hpcp_wdata, cntinten_wen, cntof_wen, cnt_of_pulse, hpcp_int_gen_en,
      output cntinten, cntof, hpcp_int_req, hpcp_int_idx
   );
endinterface

// File: rtl/aq_hpcp_cntint_ctrl.sv
// Purpose : per-counter interrupt-enable and sticky overflow-status registers,
//           plus a registered interrupt request and lowest pending index.
// Latency : register writes/pulses visible 1 edge later; req/idx 2 edges after a pulse.
// Backpressure: none; every write and overflow pulse is accepted each cycle.
// Ports   : hpcp_clk, cpurst_b (async active-low) and bus (slave side):
//           hpcp_wdata, cntinten_wen, cntof_wen, cnt_of_pulse, hpcp_int_gen_en in;
//           cntinten, cntof, hpcp_int_req, hpcp_int_idx out.
module aq_hpcp_cntint_ctrl #(
   parameter int CNT_NUM = 32,
   parameter int IDX_W   = 5
) (
   input  logic                  hpcp_clk,
   input  logic                  cpurst_b,
   aq_hpcp_cntint_ctrl_if.slave  bus
);

   logic [CNT_NUM-1:0] cntinten_q;
   logic [CNT_NUM-1:0] cntof_q;
   logic               int_req_q;
   logic [IDX_W-1:0]   int_idx_q;

   logic [CNT_NUM-1:0] pend;
   logic               pend_any;
   logic [IDX_W-1:0]   pend_idx;

   assign pend     = cntof_q & cntinten_q;
   assign pend_any = |pend;

   // Lowest-numbered pending counter wins: scan downwards so the last hit
   // is the lowest index. Codes >= CNT_NUM can never be produced.
   always_comb begin
      pend_idx = '0;
      for (int i = CNT_NUM - 1; i >= 0; i--) begin
         if (pend[i]) begin
            pend_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         cntinten_q <= '0;
         cntof_q    <= '0;
         int_req_q  <= 1'b0;
         int_idx_q  <= '0;
      end else begin
         cntinten_q <= (cntinten_q & ~bus.cntinten_wen) |
                       (bus.hpcp_wdata & bus.cntinten_wen);
         // Overflow pulse ORs in after the software write so a simultaneous
         // clear never loses an event.
         cntof_q    <= (cntof_q & ~bus.cntof_wen) |
                       (bus.hpcp_wdata & bus.cntof_wen) |
                       bus.cnt_of_pulse;
         int_req_q  <= bus.hpcp_int_gen_en & pend_any;
         // Index tracks pending state regardless of the global enable and
         // holds its last value once nothing is pending.
         if (pend_any) begin
            int_idx_q <= pend_idx;
         end
      end
   end

   assign bus.cntinten     = cntinten_q;
   assign bus.cntof        = cntof_q;
   assign bus.hpcp_int_req = int_req_q;
   assign bus.hpcp_int_idx = int_idx_q;

endmodule

// File: tb/tb_aq_hpcp_cntint_ctrl.sv
// Purpose : self-checking bench for aq_hpcp_cntint_ctrl: directed vector table,
//           reset corner sequence and randomized run against a reference model.
// Ports   : none (top level); drives the controller through its interface.
module tb_aq_hpcp_cntint_ctrl;

   localparam int N = 32;
   localparam int W = 5;

   logic hpcp_clk = 1'b0;
   logic cpurst_b = 1'b0;

   always #5 hpcp_clk = ~hpcp_clk;

   aq_hpcp_cntint_ctrl_if #(.CNT_NUM(N), .IDX_W(W)) bus ();

   aq_hpcp_cntint_ctrl #(.CNT_NUM(N), .IDX_W(W)) dut (
      .hpcp_clk (hpcp_clk),
      .cpurst_b (cpurst_b),
      .bus      (bus)
   );

   logic [N-1:0] w_wdata, w_ien_wen, w_of_wen, w_pulse;
   logic         w_gen;

   assign bus.hpcp_wdata      = w_wdata;
   assign bus.cntinten_wen    = w_ien_wen;
   assign bus.cntof_wen       = w_of_wen;
   assign bus.cnt_of_pulse    = w_pulse;
   assign bus.hpcp_int_gen_en = w_gen;

   // Reference model state
   logic [N-1:0] m_ien, m_of;
   logic         m_req;
   logic [W-1:0] m_idx;

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      logic [N-1:0] wdata, ien_wen, of_wen, pulse;
      logic         gen;
      logic [N-1:0] e_ien, e_of;
      logic         e_req;
      logic [W-1:0] e_idx;
   } vec_t;

   vec_t tbl [22];

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Position of the lowest set bit: isolate it with two's complement,
   // then count how far it sits from bit 0.
   function automatic logic [W-1:0] lowest_bit(input logic [N-1:0] v);
      logic [N-1:0] iso;
      int k;
      iso = v & (~v + 1'b1);
      k = 0;
      while (iso > 1) begin
         iso = iso >> 1;
         k++;
      end
      return W'(k);
   endfunction

   task automatic set_in(input logic [N-1:0] wd, input logic [N-1:0] ie,
                         input logic [N-1:0] oe, input logic [N-1:0] pu, input logic g);
      w_wdata = wd; w_ien_wen = ie; w_of_wen = oe; w_pulse = pu; w_gen = g;
   endtask

   // Advance one clock; model computes what the spec says the registers
   // should hold after this edge, outputs are sampled 1 time unit later.
   task automatic step();
      logic [N-1:0] n_ien, n_of, pend;
      logic         n_req;
      logic [W-1:0] n_idx;
      n_ien = m_ien;
      n_of  = m_of;
      for (int i = 0; i < N; i++) begin
         if (w_ien_wen[i]) n_ien[i] = w_wdata[i];
         if (w_of_wen[i])  n_of[i]  = w_wdata[i];
         if (w_pulse[i])   n_of[i]  = 1'b1;
      end
      pend  = m_of & m_ien;
      n_req = w_gen && (pend != 0);
      n_idx = (pend != 0) ? lowest_bit(pend) : m_idx;
      @(posedge hpcp_clk);
      #1;
      if (cpurst_b) begin
         m_ien = n_ien; m_of = n_of; m_req = n_req; m_idx = n_idx;
      end
   endtask

   task automatic chk_all(input string tag, input logic [N-1:0] ien, input logic [N-1:0] of,
                          input logic req, input logic [W-1:0] idx);
      chk({tag, ".cntinten"}, bus.cntinten, ien);
      chk({tag, ".cntof"},    bus.cntof, of);
      chk({tag, ".req"},      {31'd0, bus.hpcp_int_req}, {31'd0, req});
      chk({tag, ".idx"},      {27'd0, bus.hpcp_int_idx}, {27'd0, idx});
   endtask

   initial begin
      //                wdata         ien_wen       of_wen        pulse         gen   e_ien         e_of          req   idx
      tbl[0]  = '{32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 5'd0};
      tbl[1]  = '{32'hFFFF_FFFF,32'h0000_00F0,32'h0,        32'h0,        1'b0, 32'h0000_00F0,32'h0,        1'b0, 5'd0};
      tbl[2]  = '{32'h0,        32'h0000_0010,32'h0,        32'h0,        1'b0, 32'h0000_00E0,32'h0,        1'b0, 5'd0};
      tbl[3]  = '{32'h8,        32'hFFFF_FFFF,32'h0,        32'h0,        1'b1, 32'h8,        32'h0,        1'b0, 5'd0};
      tbl[4]  = '{32'h0,        32'h0,        32'h0,        32'h8,        1'b1, 32'h8,        32'h8,        1'b0, 5'd0};
      tbl[5]  = '{32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 32'h8,        32'h8,        1'b1, 5'd3};
      tbl[6]  = '{32'h0,        32'h0,        32'h8,        32'h0,        1'b1, 32'h8,        32'h0,        1'b1, 5'd3};
      tbl[7]  = '{32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 32'h8,        32'h0,        1'b0, 5'd3};
      tbl[8]  = '{32'h0,        32'h0,        32'h1,        32'h1,        1'b1, 32'h8,        32'h1,        1'b0, 5'd3};
      tbl[9]  = '{32'h8000_0104,32'h0,        32'hFFFF_FFFF,32'h0,        1'b1, 32'h8,        32'h8000_0104,1'b0, 5'd3};
      tbl[10] = '{32'h8000_0100,32'hFFFF_FFFF,32'h0,        32'h0,        1'b1, 32'h8000_0100,32'h8000_0104,1'b0, 5'd3};
      tbl[11] = '{32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 32'h8000_0100,32'h8000_0104,1'b1, 5'd8};
      tbl[12] = '{32'h0,        32'h0000_0100,32'h0,        32'h0,        1'b1, 32'h8000_0000,32'h8000_0104,1'b1, 5'd8};
      tbl[13] = '{32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 32'h8000_0000,32'h8000_0104,1'b1, 5'd31};
      tbl[14] = '{32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 32'h8000_0000,32'h8000_0104,1'b0, 5'd31};
      tbl[15] = '{32'h0,        32'hFFFF_FFFF,32'hFFFF_FFFF,32'h0,        1'b1, 32'h0,        32'h0,        1'b1, 5'd31};
      tbl[16] = '{32'h0,        32'h0,        32'h0,        32'h20,       1'b1, 32'h0,        32'h20,       1'b0, 5'd31};
      tbl[17] = '{32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 32'h0,        32'h20,       1'b0, 5'd31};
      tbl[18] = '{32'hFFFF_FFFF,32'h20,       32'h0,        32'h0,        1'b1, 32'h20,       32'h20,       1'b0, 5'd31};
      tbl[19] = '{32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 32'h20,       32'h20,       1'b1, 5'd5};
      tbl[20] = '{32'h3,        32'h3,        32'h3,        32'h0,        1'b1, 32'h23,       32'h23,       1'b1, 5'd5};
      tbl[21] = '{32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 32'h23,       32'h23,       1'b1, 5'd0};

      set_in('0, '0, '0, '0, 1'b0);
      m_ien = '0; m_of = '0; m_req = 1'b0; m_idx = '0;

      // Reset state while held in reset
      #12;
      chk_all("reset", '0, '0, 1'b0, '0);
      @(negedge hpcp_clk);
      cpurst_b = 1'b1;

      // Directed vectors
      for (int r = 0; r < 22; r++) begin
         set_in(tbl[r].wdata, tbl[r].ien_wen, tbl[r].of_wen, tbl[r].pulse, tbl[r].gen);
         step();
         chk_all($sformatf("vec%0d", r), tbl[r].e_ien, tbl[r].e_of, tbl[r].e_req, tbl[r].e_idx);
      end

      // Mid-run asynchronous reset with everything set and req asserted
      set_in(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 1'b1);
      step();
      set_in('0, '0, '0, '0, 1'b1);
      step();
      chk_all("pre_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd0);
      #2;
      cpurst_b = 1'b0;
      m_ien = '0; m_of = '0; m_req = 1'b0; m_idx = '0;
      #1;
      chk_all("async_rst", '0, '0, 1'b0, '0);
      // Pulses during reset are dropped
      set_in('0, '0, '0, 32'hFFFF_FFFF, 1'b1);
      step();
      step();
      chk_all("rst_pulse", '0, '0, 1'b0, '0);
      set_in('0, '0, '0, '0, 1'b0);
      cpurst_b = 1'b1;
      step();
      step();
      chk_all("post_rst", '0, '0, 1'b0, '0);

      // Randomized run against the reference model
      for (int c = 0; c < 600; c++) begin
         set_in($urandom,
                $urandom & $urandom & $urandom,
                $urandom & $urandom & $urandom,
                $urandom & $urandom & $urandom & $urandom,
                ($urandom_range(0, 7) != 0));
         step();
         chk_all($sformatf("rnd%0d", c), m_ien, m_of, m_req, m_idx);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/aq_hpcp_cntint_ctrl.md
Name: aq_hpcp_cntint_ctrl

Overview:
- Parametrised per-counter interrupt-enable and overflow-status controller for the HPCP performance-counter block.
- Holds an N-bit interrupt-enable vector and an N-bit sticky overflow-status vector, both with per-bit write enables.
- Registers counter overflow pulses into the status vector.
- Drives a single registered interrupt request plus the index of the lowest-numbered pending, enabled counter to the core interrupt logic.

Parameters:
- CNT_NUM, 32, number of counters/channels (1..32).
- IDX_W, 5, width of the index output; must satisfy 2^IDX_W >= CNT_NUM.

Ports:
- hpcp_clk  input  1  block clock.
- cpurst_b  input  1  asynchronous active-low reset.
- hpcp_wdata  input  CNT_NUM  software write data, shared by both registers.
- cntinten_wen  input  CNT_NUM  per-bit write enable, interrupt-enable vector.
- cntof_wen  input  CNT_NUM  per-bit write enable, overflow-status vector.
- cnt_of_pulse  input  CNT_NUM  one-cycle overflow event per counter.
- hpcp_int_gen_en  input  1  global interrupt enable (counter-overflow interrupts allowed).
- cntinten  output  CNT_NUM  interrupt-enable vector.
- cntof  output  CNT_NUM  sticky overflow-status vector.
- hpcp_int_req  output  1  registered interrupt request, level.
- hpcp_int_idx  output  IDX_W  index of lowest pending+enabled counter, registered.

Behaviour:
- Clock and reset: one clock, hpcp_clk. Reset cpurst_b is asynchronous and active-low.
- Reset values: cntinten=0, cntof=0, hpcp_int_req=0, hpcp_int_idx=0.
- cntinten, per bit i, each rising edge:
  - cntinten_wen[i]=1: load hpcp_wdata[i].
  - Otherwise: hold.
  - No hardware update path.
- cntof, per bit i, each rising edge:
  - next = (cntof_wen[i] ? hpcp_wdata[i] : cntof[i]) | cnt_of_pulse[i].
  - A simultaneous software write of 0 and an overflow pulse leaves the bit at 1. Hardware set wins, so no event is lost.
  - A software write of 1 sets the bit.
  - An overflow with cntinten[i]=0 still sets cntof[i]. Status records regardless of enable.
- Pending vector: pend = cntof & cntinten. Combinational, from current register values.
- hpcp_int_req: registered next = hpcp_int_gen_en & (|pend).
  - Latency: overflow pulse in cycle T sets cntof at edge T+1. hpcp_int_req rises at edge T+2 (two edges).
  - Deasserts one edge after the pending condition clears. Clearing occurs by cntof write 0, cntinten write 0, or hpcp_int_gen_en=0.
- hpcp_int_idx: registered.
  - When |pend, next = index of lowest set bit of pend.
  - When pend=0, holds its last value.
  - Updated independently of hpcp_int_gen_en.
  - Meaningful only while hpcp_int_req=1.
- Simultaneous writes: cntinten_wen and cntof_wen asserted together write the same hpcp_wdata bits to both registers in the same cycle.
- Unused index codes (>= CNT_NUM) are never produced.
- Reset mid-operation: all state clears immediately on cpurst_b fall. Pulses during reset are dropped. The first edge after reset release behaves as normal.
- CNT_NUM=1: the priority encoder reduces to constant 0.

Test Plan:
- Reset/defaults: assert cpurst_b=0 mid-run with cntof=0xFFFF_FFFF -> all outputs 0 asynchronously. After release, outputs hold 0 with no stimulus.
- Enable programming: write cntinten_wen=0x0000_00F0, hpcp_wdata=0xFFFF_FFFF -> cntinten=0x0000_00F0. Then write cntinten_wen=0x0000_0010 with data 0 -> cntinten=0x0000_00E0.
- Overflow to interrupt:
  - Setup: cntinten=0x0000_0008, hpcp_int_gen_en=1.
  - Stimulus: cnt_of_pulse=0x0000_0008 in cycle T.
  - Response: cntof=0x8 after edge T+1; hpcp_int_req=1 and hpcp_int_idx=3 after edge T+2.
  - Clear: cntof_wen=0x8, data 0 -> req=0 two edges later.
- Set-wins collision: in the same cycle, cntof_wen=0x1, hpcp_wdata=0, cnt_of_pulse=0x1 -> cntof[0]=1 after the edge.
- Priority and masking:
  - Setup: cntof=0x8000_0104, cntinten=0x8000_0100.
  - Response: idx=8, req=1.
  - Disable bit 8 -> idx=31.
  - Drop hpcp_int_gen_en -> req=0 next edge, idx stays 31.
- Disabled overflow: cntinten=0, pulse bit 5 -> cntof=0x20, req stays 0. Later enable bit 5 -> req=1 two edges after the write, idx=5.
